// File: rtl/cipher_vault_ctrl.sv
// ============================================================================
// cipher_vault_ctrl : byte-serial keyed cipher sequencer with 10-entry vault,
// constant-time decrypt authentication, lockout and status window timing.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cipher_vault_ctrl #(
   parameter int          DEPTH      = 10,
   parameter int          MAX_TRIES  = 3,
   parameter int          HOLD_TICKS = 3,
   parameter logic [7:0]  IV         = 8'd5
) (
   input  logic        msclk,
   input  logic        rst_n,
   input  logic        enc_req,
   input  logic        dec_req,
   input  logic [7:0]  key,
   input  logic [79:0] code_in,
   input  logic        tick_1hz,
   output logic        busy,
   output logic        done,
   output logic        ok,
   output logic        fail,
   output logic [79:0] code_out,
   output logic [3:0]  count,
   output logic        vault_full,
   output logic [1:0]  tries_left,
   output logic        locked,
   output logic        status_active
);

   localparam int          TW         = $clog2(HOLD_TICKS + 1);
   localparam logic [3:0]  LAST_SLOT  = 4'(DEPTH - 1);
   localparam logic [3:0]  LAST_BYTE  = 4'd9;
   localparam logic [3:0]  DEPTH_L    = 4'(DEPTH);
   localparam logic [1:0]  TRIES_INIT = 2'(MAX_TRIES);
   localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_TICKS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SEARCH = 3'd1,
      S_CRYPT  = 3'd2,
      S_STORE  = 3'd3,
      S_FINISH = 3'd4,
      S_LOCKED = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic          is_enc_q, is_enc_d;
   logic [79:0]   data_q, data_d;
   logic [7:0]    key_q, key_d;
   logic [7:0]    prev_q, prev_d;
   logic [3:0]    step_q, step_d;
   logic          hit_q, hit_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          ok_q, ok_d;
   logic          fail_q, fail_d;
   logic [79:0]   code_out_q, code_out_d;
   logic [3:0]    count_q, count_d;
   logic [1:0]    tries_q, tries_d;
   logic          locked_q, locked_d;
   logic          status_q, status_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [79:0]   slot_code_q [DEPTH];
   logic [79:0]   slot_code_d [DEPTH];
   logic [7:0]    slot_key_q  [DEPTH];
   logic [7:0]    slot_key_d  [DEPTH];
   logic [DEPTH-1:0] slot_valid_q, slot_valid_d;

   logic [7:0] byte_in, enc_sum, dec_diff, byte_out, prev_next;
   logic       slot_match;

   // Zero bytes bypass the cipher and leave the chaining value untouched.
   always_comb begin
      byte_in  = data_q[79:72];
      enc_sum  = prev_q + key_q + byte_in;
      dec_diff = byte_in - prev_q - key_q;
      byte_out = 8'd0;
      prev_next = prev_q;
      if (byte_in != 8'd0) begin
         if (is_enc_q) begin
            byte_out  = {2'b00, enc_sum[5:0]};
            prev_next = byte_in;
         end else begin
            byte_out  = {2'b00, dec_diff[5:0]};
            prev_next = byte_out;
         end
      end
      slot_match = slot_valid_q[step_q] && (slot_code_q[step_q] == data_q)
                   && (slot_key_q[step_q] == key_q);
   end

   always_comb begin
      state_d      = state_q;
      is_enc_d     = is_enc_q;
      data_d       = data_q;
      key_d        = key_q;
      prev_d       = prev_q;
      step_d       = step_q;
      hit_d        = hit_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      ok_d         = ok_q;
      fail_d       = fail_q;
      code_out_d   = code_out_q;
      count_d      = count_q;
      tries_d      = tries_q;
      locked_d     = locked_q;
      status_d     = status_q;
      tick_cnt_d   = tick_cnt_q;
      slot_code_d  = slot_code_q;
      slot_key_d   = slot_key_q;
      slot_valid_d = slot_valid_q;

      case (state_q)
         S_IDLE: begin
            if (enc_req || dec_req) begin
               data_d   = code_in;
               key_d    = key;
               prev_d   = IV;
               step_d   = 4'd0;
               hit_d    = 1'b0;
               busy_d   = 1'b1;
               ok_d     = 1'b0;
               fail_d   = 1'b0;
               is_enc_d = enc_req;
               state_d  = enc_req ? S_CRYPT : S_SEARCH;
            end
         end
         // Every slot is visited regardless of an early hit so timing leaks nothing.
         S_SEARCH: begin
            hit_d = hit_q | slot_match;
            if (step_q == LAST_SLOT) begin
               step_d  = 4'd0;
               state_d = (hit_q | slot_match) ? S_CRYPT : S_FINISH;
            end else begin
               step_d = step_q + 4'd1;
            end
         end
         S_CRYPT: begin
            data_d = {data_q[71:0], byte_out};
            prev_d = prev_next;
            if (step_q == LAST_BYTE) begin
               step_d  = 4'd0;
               state_d = is_enc_q ? S_STORE : S_FINISH;
            end else begin
               step_d = step_q + 4'd1;
            end
         end
         S_STORE: begin
            done_d     = 1'b1;
            busy_d     = 1'b0;
            code_out_d = data_q;
            if (count_q < DEPTH_L) begin
               slot_code_d[count_q]  = data_q;
               slot_key_d[count_q]   = key_q;
               slot_valid_d[count_q] = 1'b1;
               count_d = count_q + 4'd1;
               ok_d    = 1'b1;
            end else begin
               fail_d = 1'b1;
            end
            state_d = S_IDLE;
         end
         S_FINISH: begin
            done_d = 1'b1;
            busy_d = 1'b0;
            if (hit_q) begin
               ok_d       = 1'b1;
               code_out_d = data_q;
               tries_d    = TRIES_INIT;
               state_d    = S_IDLE;
            end else begin
               fail_d     = 1'b1;
               code_out_d = 80'd0;
               tries_d    = tries_q - 2'd1;
               if (tries_q == 2'd1) begin
                  locked_d = 1'b1;
                  state_d  = S_LOCKED;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_LOCKED: state_d = S_LOCKED;
         default:  state_d = S_IDLE;
      endcase

      // A tick coinciding with the done pulse does not advance the window.
      if (done_d) begin
         status_d   = 1'b1;
         tick_cnt_d = '0;
      end else if (locked_q) begin
         status_d = 1'b1;
      end else if (status_q && tick_1hz && !done_q) begin
         if (tick_cnt_q == HOLD_LAST) begin
            status_d   = 1'b0;
            tick_cnt_d = '0;
         end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge msclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         is_enc_q     <= 1'b0;
         data_q       <= '0;
         key_q        <= '0;
         prev_q       <= '0;
         step_q       <= '0;
         hit_q        <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         ok_q         <= 1'b0;
         fail_q       <= 1'b0;
         code_out_q   <= '0;
         count_q      <= '0;
         tries_q      <= TRIES_INIT;
         locked_q     <= 1'b0;
         status_q     <= 1'b0;
         tick_cnt_q   <= '0;
         slot_code_q  <= '{default: '0};
         slot_key_q   <= '{default: '0};
         slot_valid_q <= '0;
      end else begin
         state_q      <= state_d;
         is_enc_q     <= is_enc_d;
         data_q       <= data_d;
         key_q        <= key_d;
         prev_q       <= prev_d;
         step_q       <= step_d;
         hit_q        <= hit_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         ok_q         <= ok_d;
         fail_q       <= fail_d;
         code_out_q   <= code_out_d;
         count_q      <= count_d;
         tries_q      <= tries_d;
         locked_q     <= locked_d;
         status_q     <= status_d;
         tick_cnt_q   <= tick_cnt_d;
         slot_code_q  <= slot_code_d;
         slot_key_q   <= slot_key_d;
         slot_valid_q <= slot_valid_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign ok            = ok_q;
   assign fail          = fail_q;
   assign code_out      = code_out_q;
   assign count         = count_q;
   assign vault_full    = (count_q == DEPTH_L);
   assign tries_left    = tries_q;
   assign locked        = locked_q;
   assign status_active = status_q;

endmodule

`default_nettype wire

// File: tb/tb_cipher_vault_ctrl.sv
// ============================================================================
// tb_cipher_vault_ctrl : directed self-checking bench for cipher_vault_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cipher_vault_ctrl;

   logic        msclk = 1'b0;
   logic        rst_n;
   logic        enc_req, dec_req, tick_1hz;
   logic [7:0]  key;
   logic [79:0] code_in;
   logic        busy, done, ok, fail, vault_full, locked, status_active;
   logic [79:0] code_out;
   logic [3:0]  count;
   logic [1:0]  tries_left;

   int n_assert = 0;
   int n_fail   = 0;

   cipher_vault_ctrl dut (
      .msclk(msclk), .rst_n(rst_n), .enc_req(enc_req), .dec_req(dec_req),
      .key(key), .code_in(code_in), .tick_1hz(tick_1hz),
      .busy(busy), .done(done), .ok(ok), .fail(fail), .code_out(code_out),
      .count(count), .vault_full(vault_full), .tries_left(tries_left),
      .locked(locked), .status_active(status_active)
   );

   always #5 msclk = ~msclk;

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Reference encryption used to predict vault entries for the fill loop.
   function automatic logic [79:0] enc_model(input logic [79:0] c, input logic [7:0] k);
      logic [7:0] prev, b, s;
      logic [79:0] r;
      prev = 8'd5;
      r = '0;
      for (int i = 9; i >= 0; i--) begin
         b = c[i*8 +: 8];
         if (b == 8'd0) begin
            r[i*8 +: 8] = 8'd0;
         end else begin
            s = prev + k + b;
            r[i*8 +: 8] = {2'b00, s[5:0]};
            prev = b;
         end
      end
      return r;
   endfunction

   task automatic req(input logic e, input logic d, input logic [79:0] c,
                      input logic [7:0] k, output int lat);
      @(negedge msclk);
      enc_req = e; dec_req = d; code_in = c; key = k;
      @(posedge msclk); #1;
      enc_req = 1'b0; dec_req = 1'b0;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge msclk); #1;
         if (done === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic tick();
      @(negedge msclk);
      tick_1hz = 1'b1;
      @(posedge msclk); #1;
      tick_1hz = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      int dones;
      int busy_seen;
      logic [79:0] exp_code;

      rst_n = 1'b0; enc_req = 1'b0; dec_req = 1'b0; tick_1hz = 1'b0;
      key = 8'd0; code_in = 80'd0;
      repeat (2) @(posedge msclk);
      #1;
      chk("rst_busy",   80'(busy), 80'd0);
      chk("rst_done",   80'(done), 80'd0);
      chk("rst_ok",     80'(ok), 80'd0);
      chk("rst_fail",   80'(fail), 80'd0);
      chk("rst_code",   code_out, 80'd0);
      chk("rst_count",  80'(count), 80'd0);
      chk("rst_tries",  80'(tries_left), 80'd3);
      chk("rst_locked", 80'(locked), 80'd0);
      chk("rst_status", 80'(status_active), 80'd0);
      @(negedge msclk);
      rst_n = 1'b1;

      // Decrypt of zero code on an empty vault must miss.
      req(1'b0, 1'b1, 80'd0, 8'h00, lat);
      chk("dec0_lat",   80'(lat), 80'd11);
      chk("dec0_fail",  80'(fail), 80'd1);
      chk("dec0_ok",    80'(ok), 80'd0);
      chk("dec0_code",  code_out, 80'd0);
      chk("dec0_tries", 80'(tries_left), 80'd2);
      chk("dec0_stat",  80'(status_active), 80'd1);

      // Encrypt 0x1122 with key 1 -> 0x1734.
      req(1'b1, 1'b0, 80'h1122, 8'h01, lat);
      chk("enc1_lat",   80'(lat), 80'd11);
      chk("enc1_ok",    80'(ok), 80'd1);
      chk("enc1_fail",  80'(fail), 80'd0);
      chk("enc1_code",  code_out, 80'h1734);
      chk("enc1_count", 80'(count), 80'd1);
      chk("enc1_tries", 80'(tries_left), 80'd2);

      // Status window: falls on the third tick after done.
      @(posedge msclk); #1;
      tick();
      tick();
      chk("stat_tick2", 80'(status_active), 80'd1);
      tick();
      chk("stat_tick3", 80'(status_active), 80'd0);

      // Decrypt hit.
      req(1'b0, 1'b1, 80'h1734, 8'h01, lat);
      chk("dec1_lat",   80'(lat), 80'd21);
      chk("dec1_ok",    80'(ok), 80'd1);
      chk("dec1_code",  code_out, 80'h1122);
      chk("dec1_tries", 80'(tries_left), 80'd3);

      // Simultaneous requests: encrypt wins.
      req(1'b1, 1'b1, 80'h0102, 8'h02, lat);
      chk("both_lat",   80'(lat), 80'd11);
      chk("both_ok",    80'(ok), 80'd1);
      chk("both_code",  code_out, 80'h0805);
      chk("both_count", 80'(count), 80'd2);

      // dec_req while busy is ignored.
      @(negedge msclk);
      enc_req = 1'b1; code_in = 80'h0304; key = 8'h03;
      @(posedge msclk); #1;
      enc_req = 1'b0;
      repeat (3) @(posedge msclk);
      @(negedge msclk);
      dec_req = 1'b1; code_in = 80'h1734; key = 8'h01;
      @(posedge msclk); #1;
      dec_req = 1'b0;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge msclk); #1;
         if (done === 1'b1) begin
            dones++;
            exp_code = code_out;
         end
      end
      chk("busyign_dones", 80'(dones), 80'd1);
      chk("busyign_code",  exp_code, 80'h0B0A);
      chk("busyign_count", 80'(count), 80'd3);
      chk("busyign_busy",  80'(busy), 80'd0);

      // Fill remaining seven slots.
      for (int i = 1; i <= 7; i++) begin
         req(1'b1, 1'b0, {72'd0, 8'(i + 16)}, 8'h01, lat);
         chk("fill_lat",  80'(lat), 80'd11);
         chk("fill_code", code_out, enc_model({72'd0, 8'(i + 16)}, 8'h01));
         if (i == 6) chk("fill_notfull", 80'(vault_full), 80'd0);
      end
      chk("full_count", 80'(count), 80'd10);
      chk("full_flag",  80'(vault_full), 80'd1);

      req(1'b1, 1'b0, 80'h33, 8'h07, lat);
      chk("enc11_lat",   80'(lat), 80'd11);
      chk("enc11_fail",  80'(fail), 80'd1);
      chk("enc11_ok",    80'(ok), 80'd0);
      chk("enc11_code",  code_out, 80'h3F);
      chk("enc11_count", 80'(count), 80'd10);

      req(1'b0, 1'b1, 80'h3F, 8'h07, lat);
      chk("dec11_lat",   80'(lat), 80'd11);
      chk("dec11_fail",  80'(fail), 80'd1);
      chk("dec11_tries", 80'(tries_left), 80'd2);

      req(1'b0, 1'b1, 80'h1734, 8'h01, lat);
      chk("dec2_lat",   80'(lat), 80'd21);
      chk("dec2_code",  code_out, 80'h1122);
      chk("dec2_tries", 80'(tries_left), 80'd3);

      // Three wrong-key attempts lead to lockout.
      for (int i = 0; i < 3; i++) begin
         req(1'b0, 1'b1, 80'h1734, 8'h02, lat);
         chk("miss_lat",   80'(lat), 80'd11);
         chk("miss_fail",  80'(fail), 80'd1);
         chk("miss_code",  code_out, 80'd0);
         chk("miss_tries", 80'(tries_left), 80'(2 - i));
      end
      chk("lock_locked", 80'(locked), 80'd1);

      @(negedge msclk);
      enc_req = 1'b1; code_in = 80'h1122; key = 8'h01;
      @(posedge msclk); #1;
      enc_req = 1'b0;
      busy_seen = 0;
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge msclk); #1;
         if (busy === 1'b1) busy_seen++;
         if (done === 1'b1) dones++;
      end
      chk("lock_nobusy", 80'(busy_seen), 80'd0);
      chk("lock_nodone", 80'(dones), 80'd0);
      tick(); tick(); tick();
      chk("lock_status", 80'(status_active), 80'd1);

      // Reset clears the lock, then reset again in the middle of CRYPT.
      @(negedge msclk); rst_n = 1'b0;
      @(negedge msclk); rst_n = 1'b1;
      chk("rel_locked", 80'(locked), 80'd0);
      @(negedge msclk);
      enc_req = 1'b1; code_in = 80'h1122; key = 8'h01;
      @(posedge msclk); #1;
      enc_req = 1'b0;
      repeat (4) @(posedge msclk);
      #1;
      chk("mid_busy", 80'(busy), 80'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy",   80'(busy), 80'd0);
      chk("mid_rst_done",   80'(done), 80'd0);
      chk("mid_rst_ok",     80'(ok), 80'd0);
      chk("mid_rst_fail",   80'(fail), 80'd0);
      chk("mid_rst_code",   code_out, 80'd0);
      chk("mid_rst_count",  80'(count), 80'd0);
      chk("mid_rst_tries",  80'(tries_left), 80'd3);
      chk("mid_rst_locked", 80'(locked), 80'd0);
      chk("mid_rst_status", 80'(status_active), 80'd0);
      @(negedge msclk); rst_n = 1'b1;
      repeat (15) @(posedge msclk);
      #1;
      chk("post_rst_count", 80'(count), 80'd0);
      chk("post_rst_busy",  80'(busy), 80'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
